// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the fetch/decode boundary: instruction field
// positions and skid-buffer occupancy state encoding.
package if_id_stage_pkg;

   // Instruction field bit positions (16-bit ISA)
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int RA_HI  = 11;
   localparam int RA_LO  = 9;
   localparam int RB_HI  = 8;
   localparam int RB_LO  = 6;
   localparam int IMM_HI = 5;
   localparam int IMM_LO = 0;

   // Skid buffer occupancy
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } ifid_state_e;

endpackage

// File: rtl/if_id_stage_instr_fields.sv
// Combinational instruction slicer: splits an instruction word into
// opcode, register specifiers and the raw 6-bit immediate.
module instr_fields
   import if_id_stage_pkg::*;
#(
   parameter int INSTR_W = 16
) (
   input  logic [INSTR_W-1:0] instr,
   output logic [3:0]         opcode,
   output logic [2:0]         ra,
   output logic [2:0]         rb,
   output logic [5:0]         imm6
);

   assign opcode = instr[OPC_HI:OPC_LO];
   assign ra     = instr[RA_HI:RA_LO];
   assign rb     = instr[RB_HI:RB_LO];
   assign imm6   = instr[IMM_HI:IMM_LO];

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: two-entry skid buffer between fetch and decode,
// flush on redirect, saturating downstream stall counter.
module if_id_stage
   import if_id_stage_pkg::*;
#(
   parameter int INSTR_W = 16,
   parameter int PC_W    = 16,
   parameter int STALL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [3:0]         out_opcode,
   output logic [2:0]         out_ra,
   output logic [2:0]         out_rb,
   output logic [5:0]         out_imm6,
   input  logic               stall_clr,
   output logic [STALL_W-1:0] stall_cnt
);

   localparam logic [STALL_W-1:0] STALL_MAX = '1;

   ifid_state_e        state_q, state_d;
   logic [INSTR_W-1:0] main_instr, skid_instr;
   logic [PC_W-1:0]    main_pc, skid_pc;
   logic               in_ready_q;
   logic               in_fire, out_fire;
   logic               ld_main_in, ld_main_skid, ld_skid;

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign in_fire   = in_valid & in_ready_q;
   assign out_fire  = out_valid & out_ready;
   assign out_instr = main_instr;
   assign out_pc    = main_pc;

   // Next occupancy and register load selects; flush overrides everything
   always_comb begin
      state_d      = state_q;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (in_fire) begin
               state_d    = ONE;
               ld_main_in = 1'b1;
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  ld_main_in = 1'b1;
               end else if (in_fire) begin
                  state_d = TWO;
                  ld_skid = 1'b1;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            TWO: if (out_fire) begin
               state_d      = ONE;
               ld_main_skid = 1'b1;
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Occupancy register; in_ready is registered from the next state so
   // there is no combinational out_ready -> in_ready path
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != TWO);
      end
   end

   // Main (output-facing) and skid data registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_instr <= '0;
         main_pc    <= '0;
         skid_instr <= '0;
         skid_pc    <= '0;
      end else begin
         if (ld_main_in) begin
            main_instr <= in_instr;
            main_pc    <= in_pc;
         end else if (ld_main_skid) begin
            main_instr <= skid_instr;
            main_pc    <= skid_pc;
         end
         if (ld_skid) begin
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
         end
      end
   end

   // Saturating count of cycles decode held off a valid instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall_clr) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != STALL_MAX)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   instr_fields #(.INSTR_W(INSTR_W)) u_fields (
      .instr  (main_instr),
      .opcode (out_opcode),
      .ra     (out_ra),
      .rb     (out_rb),
      .imm6   (out_imm6)
   );

endmodule
